// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Latency: n/a (constants only).
// Backpressure: n/a.
package muldiv_pkg;

  // Decoder op field
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  // FSM state encoding: IDLE, CALC, FIX
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the decoder (master) and the muldiv unit (slave).
// Latency: n/a (wires only).
// Backpressure: master must hold off new ops while busy; starts seen during busy are dropped.
// Ports: start/op/OP_A/OP_B/flush from master; busy/done/div_by_zero/hi/lo from slave.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] OP_A;
  logic [WIDTH-1:0] OP_B;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, OP_A, OP_B, flush,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, OP_A, OP_B, flush,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with architectural HI/LO registers.
// Latency: MULT/DIV results land WIDTH+1 edges after the accepting edge; MTHI/MTLO in one edge.
// Backpressure: busy high while iterating; starts during busy are ignored, flush aborts.
// Ports: clk, rst (async active-low), bus (slave side of muldiv_unit_if).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  logic [1:0]         state;
  logic [CW-1:0]      count;
  // Shared shift register: multiply keeps {partial product, multiplier},
  // divide keeps {partial remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_raw;    // dividend as issued, returned in HI on divide by zero
  logic               is_div;
  logic               neg_res;  // product / quotient sign
  logic               neg_rem;  // remainder follows dividend sign
  logic               b_zero;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q, dbz_q;

  // Operand conditioning for an incoming start
  logic               in_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;

  always_comb begin
    in_signed = ~bus.op[0];
    a_mag     = in_signed ? abs_w(bus.OP_A) : bus.OP_A;
    b_mag     = in_signed ? abs_w(bus.OP_B) : bus.OP_B;
  end

  // One iteration of each algorithm
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH:0]   shl;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    // Multiply: add multiplicand on LSB of multiplier, then shift right with carry.
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    mul_next = {sum, acc[WIDTH-1:1]};
    // Divide: shift left, trial subtract; a clear borrow bit keeps the difference
    // and sets the quotient bit. The remainder is always below 2*divisor, so
    // diff[WIDTH] is an exact borrow flag.
    shl  = {acc, 1'b0};
    diff = shl[2*WIDTH:WIDTH] - {1'b0, opnd};
    if (!diff[WIDTH]) begin
      div_next = {diff[WIDTH-1:0], shl[WIDTH-1:1], 1'b1};
    end else begin
      div_next = shl[2*WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      count   <= '0;
      acc     <= '0;
      opnd    <= '0;
      a_raw   <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // flush outranks start: the request is simply dropped
          if (bus.start && !bus.flush) begin
            case (bus.op)
              OP_MTHI: hi_q <= bus.OP_A;
              OP_MTLO: lo_q <= bus.OP_A;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                is_div  <= bus.op[1];
                acc     <= {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
                opnd    <= bus.op[1] ? b_mag : a_mag;
                neg_res <= in_signed & (bus.OP_A[WIDTH-1] ^ bus.OP_B[WIDTH-1]);
                neg_rem <= in_signed & bus.OP_A[WIDTH-1];
                b_zero  <= (bus.OP_B == '0);
                a_raw   <= bus.OP_A;
                dbz_q   <= 1'b0;
                count   <= '0;
                busy_q  <= 1'b1;
                state   <= CALC;
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          if (bus.flush) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            acc <= is_div ? div_next : mul_next;
            if (count == CW'(WIDTH - 1)) begin
              state <= FIX;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        FIX: begin
          busy_q <= 1'b0;
          state  <= IDLE;
          if (!bus.flush) begin
            done_q <= 1'b1;
            if (is_div && b_zero) begin
              hi_q  <= a_raw;
              lo_q  <= '1;
              dbz_q <= 1'b1;
            end else if (is_div) begin
              hi_q <= neg_w(acc[2*WIDTH-1:WIDTH], neg_rem);
              lo_q <= neg_w(acc[WIDTH-1:0], neg_res);
            end else begin
              {hi_q, lo_q} <= neg_2w(acc, neg_res);
            end
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops vs an arithmetic model.
// Latency: checks exact WIDTH+1 result timing and one-cycle done.
// Backpressure: exercises ignored starts while busy, flush in IDLE and mid-op.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests;
  int n_fail;
  logic [W-1:0] exp_hi, exp_lo;
  logic         exp_dbz;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic (SV division truncates toward zero,
  // remainder carries the dividend sign).
  task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] eh, output logic [W-1:0] el, output logic ez);
    longint          sa, sb, p;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    ez = 1'b0;
    eh = '0;
    el = '0;
    if (o[1] && b == '0) begin
      eh = a;
      el = '1;
      ez = 1'b1;
    end else begin
      case (o)
        OP_MULT:  begin p = sa * sb;  eh = p[63:32];  el = p[31:0];  end
        OP_MULTU: begin up = ua * ub; eh = up[63:32]; el = up[31:0]; end
        OP_DIV:   begin p = sa / sb;  el = p[31:0];  p = sa % sb;  eh = p[31:0];  end
        default:  begin up = ua / ub; el = up[31:0]; up = ua % ub; eh = up[31:0]; end
      endcase
    end
  endtask

  task automatic mt(input logic [2:0] o, input logic [W-1:0] a);
    @(negedge clk);
    bus.op = o; bus.OP_A = a; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (o == OP_MTHI) exp_hi = a; else exp_lo = a;
    check("mt_hi", 64'(bus.hi), 64'(exp_hi));
    check("mt_lo", 64'(bus.lo), 64'(exp_lo));
    check("mt_done", 64'(bus.done), 64'(0));
    check("mt_busy", 64'(bus.busy), 64'(0));
  endtask

  // inj: 0 none, 1 MTLO while busy, 2 flush; at: cycle after accept to inject
  task automatic exec(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                      input int inj, input int at);
    logic [W-1:0] eh, el;
    logic         ez;
    logic         flushed;
    logic         seen_done;
    model(o, a, b, eh, el, ez);
    flushed = 1'b0;
    @(negedge clk);
    bus.op = o; bus.OP_A = a; bus.OP_B = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    exp_dbz = 1'b0;
    check("start_busy", 64'(bus.busy), 64'(1));
    check("start_done", 64'(bus.done), 64'(0));
    check("start_dbz", 64'(bus.div_by_zero), 64'(0));
    for (int k = 1; k <= W && !flushed; k++) begin
      @(negedge clk);
      if (k == at && inj == 1) begin
        bus.op = OP_MTLO; bus.OP_A = 32'hDEAD_BEEF; bus.start = 1'b1;
      end
      if (k == at && inj == 2) bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      if (k == at && inj == 1) check("mt_while_busy_lo", 64'(bus.lo), 64'(exp_lo));
      if (k == at && inj == 2) begin
        check("flush_busy", 64'(bus.busy), 64'(0));
        flushed = 1'b1;
      end
    end
    if (flushed) begin
      seen_done = 1'b0;
      for (int k = 0; k < W + 3; k++) begin
        @(posedge clk); #1;
        if (bus.done) seen_done = 1'b1;
      end
      check("flush_no_done", 64'(seen_done), 64'(0));
      check("flush_hi", 64'(bus.hi), 64'(exp_hi));
      check("flush_lo", 64'(bus.lo), 64'(exp_lo));
    end else begin
      check("pre_busy", 64'(bus.busy), 64'(1));
      check("pre_done", 64'(bus.done), 64'(0));
      @(posedge clk); #1;
      exp_hi = eh; exp_lo = el; exp_dbz = ez;
      check("res_done", 64'(bus.done), 64'(1));
      check("res_busy", 64'(bus.busy), 64'(0));
      check("res_hi", 64'(bus.hi), 64'(exp_hi));
      check("res_lo", 64'(bus.lo), 64'(exp_lo));
      check("res_dbz", 64'(bus.div_by_zero), 64'(exp_dbz));
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
    rst = 1'b0;
    bus.start = 1'b0; bus.op = 3'b000; bus.OP_A = '0; bus.OP_B = '0; bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", 64'(bus.hi), 64'(0));
    check("rst_lo", 64'(bus.lo), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_dbz", 64'(bus.div_by_zero), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    // Directed cases with literal expectations
    exec(OP_MULT, 32'hFFFF_FFFF, 32'd2, 0, 0);
    check("tp_mult_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
    check("tp_mult_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFE);
    exec(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 0);
    check("tp_multu_hi", 64'(bus.hi), 64'h1);
    check("tp_multu_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFE);
    exec(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
    check("tp_div_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);
    check("tp_div_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
    exec(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    check("tp_minneg1_lo", 64'(bus.lo), 64'h0000_0000_8000_0000);
    check("tp_minneg1_hi", 64'(bus.hi), 64'h0);
    check("tp_minneg1_dbz", 64'(bus.div_by_zero), 64'h0);
    exec(OP_DIVU, 32'd7, 32'd0, 0, 0);
    check("tp_dbz_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFF);
    check("tp_dbz_hi", 64'(bus.hi), 64'h7);
    check("tp_dbz_flag", 64'(bus.div_by_zero), 64'h1);
    exec(OP_DIV, 32'hFFFF_FFF0, 32'd0, 0, 0);          // signed /0: HI keeps raw A
    exec(OP_MULT, 32'd3, 32'd5, 0, 0);                  // start clears flag (checked in exec)
    mt(OP_MTHI, 32'h0000_1234);
    mt(OP_MTLO, 32'h0000_5678);
    exec(OP_MULT, 32'd1000, 32'hFFFF_FFFD, 1, 4);       // MTLO while busy is dropped
    exec(OP_DIV, 32'd12345, 32'd17, 2, 10);             // flush mid-divide

    // flush in IDLE beats start; unused op codes do nothing
    @(negedge clk);
    bus.op = OP_MULT; bus.OP_A = 32'd9; bus.OP_B = 32'd9; bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    check("idle_flush_busy", 64'(bus.busy), 64'(0));
    @(negedge clk);
    bus.op = OP_MTHI; bus.OP_A = 32'hAAAA_5555; bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    check("idle_flush_mthi", 64'(bus.hi), 64'(exp_hi));
    @(negedge clk);
    bus.op = 3'b110; bus.OP_A = 32'h1111_1111; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("op110_busy", 64'(bus.busy), 64'(0));
    check("op110_hi", 64'(bus.hi), 64'(exp_hi));
    check("op110_lo", 64'(bus.lo), 64'(exp_lo));

    // Random mix
    for (int i = 0; i < 60; i++) begin
      int          r;
      int          sel;
      logic [2:0]  o;
      logic [W-1:0] a, b;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        mt((r == 0) ? OP_MTHI : OP_MTLO, W'($urandom));
      end else begin
        o   = 3'($urandom_range(0, 3));
        a   = W'($urandom);
        b   = W'($urandom);
        sel = $urandom_range(0, 7);
        if (sel == 0) b = '0;
        if (sel == 1) b = W'($urandom_range(1, 15));
        if (sel == 2) begin a = 32'h8000_0000; b = '1; end
        if (sel == 3) b = -W'($urandom_range(1, 15));
        if (sel == 4) a = W'($urandom_range(0, 255));
        exec(o, a, b, 0, 0);
      end
    end

    // Async reset mid-multiply
    @(negedge clk);
    bus.op = OP_MULTU; bus.OP_A = 32'hFFFF_0000; bus.OP_B = 32'h0000_FFFF; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_hi", 64'(bus.hi), 64'(0));
    check("arst_lo", 64'(bus.lo), 64'(0));
    check("arst_busy", 64'(bus.busy), 64'(0));
    check("arst_done", 64'(bus.done), 64'(0));
    check("arst_dbz", 64'(bus.div_by_zero), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
    exec(OP_DIVU, 32'd100, 32'd7, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It replaces single-cycle HI/LO handling with a shift-add multiplier and a restoring divider behind a start/busy/done handshake. It supports signed and unsigned MULT/DIV, MTHI/MTLO, divide-by-zero flagging and flush. The unit sits beside the ALU: the decoder issues ops, and MFHI/MFLO read `hi`/`lo` directly.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each WIDTH bits; WIDTH ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  op request; sampled only in IDLE.
- `op`  in  3  MULT=000, MULTU=001, DIV=010, DIVU=011, MTHI=100, MTLO=101; 110/111 ignored.
- `OP_A`  in  WIDTH  multiplicand / dividend / move source.
- `OP_B`  in  WIDTH  multiplier / divisor.
- `flush`  in  1  synchronous abort of an in-flight op.
- `busy`  out  1  high while an iterative op is in progress.
- `done`  out  1  one-cycle pulse when HI/LO receive a MULT/DIV result.
- `div_by_zero`  out  1  set by a DIV/DIVU with `OP_B`=0; held until the next accepted start.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States:
  - IDLE: waits for start.
  - CALC: WIDTH iterations.
  - FIX: sign correction and HI/LO write.
- IDLE + start + MTHI/MTLO:
  - `hi`/`lo` ← `OP_A` at that edge.
  - Stays in IDLE; no `done` pulse.
- IDLE + start + MULT/DIV family:
  - Latches |A|, |B| (signed ops) or raw operands (unsigned ops).
  - Latches result-sign bits and clears `div_by_zero`.
  - Goes to CALC with count=0.
- CALC, multiply: shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle.
- CALC, divide: restoring divide, one quotient bit per cycle.
- Leaving CALC: count reaches WIDTH−1 → FIX.
- FIX, signed multiply: 2·WIDTH product negated if the operand signs differ.
- FIX, signed divide:
  - Quotient negated if the signs differ.
  - Remainder takes the dividend's sign.
- FIX write: `hi`←product[2W−1:W] / remainder, `lo`←product[W−1:0] / quotient; pulse `done`; → IDLE.
- Divide by zero (any sign):
  - `lo`=all ones, `hi`=`OP_A` (raw).
  - `div_by_zero`=1.
  - Full latency is still spent.
- Signed MIN/−1: `lo`=MIN, `hi`=0 (falls out of the magnitude arithmetic); no flag.
- `start` while `busy`: ignored entirely; MTHI/MTLO also ignored while busy.
- `flush`:
  - In CALC/FIX → IDLE next edge; `hi`/`lo` unchanged; no `done`.
  - In IDLE it has priority over `start`, so the request is dropped.
- op 110/111: no state change.

## Timing
- Reset (async, `rst`=0): state=IDLE, `hi`=`lo`=0, `busy`=`done`=`div_by_zero`=0.
  - Applies mid-operation too; the op is lost.
- Start accepted at edge E0:
  - `busy`=1 from E0 until E0+WIDTH+1.
  - `hi`/`lo` update and `done`=1 at E0+WIDTH+1; `busy`=0 in the same cycle.
  - `done` lasts exactly one cycle.
- Total MULT/DIV latency: WIDTH+1 cycles, which is 33 at WIDTH=32.
- Back-to-back: a start sampled in the `done` cycle is accepted; there is no bubble.
- MTHI/MTLO: visible on `hi`/`lo` after one edge.
- All outputs are registered.

## Structure
- Shared package `muldiv_pkg`: op encodings (`OP_MULT` … `OP_MTLO`) and the state enum (IDLE, CALC, FIX).
- No sub-module: a single FSM plus a shared 2·WIDTH shift register serves both multiply and divide.
- Operand conditioning (abs / negate) uses local functions.

## Test plan
- MULT: A=0xFFFFFFFF, B=2 → after 33 cycles `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE, `done` for one cycle.
- MULTU: same operands → `hi`=0x00000001, `lo`=0xFFFFFFFE.
- DIV: A=−7 (0xFFFFFFF9), B=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIV: A=0x80000000, B=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU: A=7, B=0 → `lo`=0xFFFFFFFF, `hi`=7, `div_by_zero`=1.
  - A following MULT start clears `div_by_zero`.
- MTHI 0x1234 in IDLE → `hi`=0x1234 next cycle.
  - MTLO issued during MULT busy → ignored.
  - Flush at cycle 10 of a DIV → `hi`/`lo` keep their old values, no `done`.
  - `rst` low mid-MULT → all outputs 0 immediately.
